// File: rtl/fault_test_pkg.sv
// Shared types and limits for the fault test controller.
package fault_test_pkg;

  localparam int MAX_SETTLE = 4;
  localparam int SETTLE_W   = $clog2(MAX_SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ft_state_t;

endpackage

// File: rtl/ft_resp_cmp.sv
// Response checker: compares good and faulty CUT outputs on each sample strobe
// and accumulates the detection count, per-vector map and first detecting vector.
module ft_resp_cmp #(
  parameter int N_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [N_IN-1:0]      vec,
  input  logic                 z_good,
  input  logic                 z_fault,
  output logic [N_IN:0]        detect_cnt,
  output logic [(1<<N_IN)-1:0] detect_map,
  output logic [N_IN-1:0]      first_vec,
  output logic                 first_valid
);

  logic hit;

  assign hit = sample & (z_good ^ z_fault);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detect_cnt  <= '0;
      detect_map  <= '0;
      first_vec   <= '0;
      first_valid <= 1'b0;
    end else if (clear) begin
      detect_cnt  <= '0;
      detect_map  <= '0;
      first_vec   <= '0;
      first_valid <= 1'b0;
    end else if (hit) begin
      detect_map[vec] <= 1'b1;
      detect_cnt      <= detect_cnt + 1'b1;
      if (!first_valid) begin
        first_vec   <= vec;
        first_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fault_test_ctrl.sv
// Exhaustive pattern source for a fault-injection CUT: steps vec_out through
// every input vector, waits SETTLE cycles per vector, and hands samples to ft_resp_cmp.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   APPLY | vector on vec_out, settle counter loaded
//   WAIT  | settle countdown; sample CUT outputs at zero
//   DONE  | one-cycle done pulse, back to IDLE
module fault_test_ctrl
  import fault_test_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 z_good,
  input  logic                 z_fault,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        detect_cnt,
  output logic [(1<<N_IN)-1:0] detect_map,
  output logic [N_IN-1:0]      first_vec,
  output logic                 first_valid
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  ft_state_t           state, state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                clear, sample, last_vec;

  assign last_vec = &vec_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    sample    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        busy      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (settle_cnt == '0) begin
          sample    = 1'b1;
          state_nxt = last_vec ? ST_DONE : ST_APPLY;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The all-ones vector ends the run, so vec_out never wraps inside a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out    <= '0;
      settle_cnt <= '0;
    end else begin
      if (clear)                      vec_out <= '0;
      else if (sample && !last_vec)   vec_out <= vec_out + 1'b1;

      if (state == ST_APPLY)                           settle_cnt <= SETTLE_LOAD;
      else if (state == ST_WAIT && settle_cnt != '0)   settle_cnt <= settle_cnt - 1'b1;
    end
  end

  ft_resp_cmp #(.N_IN(N_IN)) u_resp_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sample      (sample),
    .vec         (vec_out),
    .z_good      (z_good),
    .z_fault     (z_fault),
    .detect_cnt  (detect_cnt),
    .detect_map  (detect_map),
    .first_vec   (first_vec),
    .first_valid (first_valid)
  );

endmodule

// File: tb/tb_fault_test_ctrl.sv
// Bench for fault_test_ctrl: CUTs modelled as truth tables, results predicted
// from the table difference, timing predicted from the per-vector cost.
module tb_fault_test_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic        zg1, zf1, zg3, zf3;
  logic [3:0]  vec1, vec3, fv1, fv3;
  logic        busy1, busy3, done1, done3, fval1, fval3;
  logic [4:0]  cnt1, cnt3;
  logic [15:0] map1, map3;

  logic [15:0] tt_good = '0, tt_fault = '0;
  bit          glitch = 1'b0;
  int          tick = 0, e0_1 = 0, e0_3 = 0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  // CUT: z_fault is forced wrong except in the cycle that ends on a sample edge.
  always_comb begin
    zg1 = tt_good[vec1];
    zf1 = tt_fault[vec1];
    if (glitch && ((tick - e0_1 + 1) % 2 != 0)) zf1 = ~zf1;
    zg3 = tt_good[vec3];
    zf3 = tt_fault[vec3];
    if (glitch && ((tick - e0_3 + 1) % 4 != 0)) zf3 = ~zf3;
  end

  fault_test_ctrl #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .z_good(zg1), .z_fault(zf1),
    .vec_out(vec1), .busy(busy1), .done(done1), .detect_cnt(cnt1),
    .detect_map(map1), .first_vec(fv1), .first_valid(fval1));

  fault_test_ctrl #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .z_good(zg3), .z_fault(zf3),
    .vec_out(vec3), .busy(busy3), .done(done3), .detect_cnt(cnt3),
    .detect_map(map3), .first_vec(fv3), .first_valid(fval3));

  task automatic set_sa0();
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      tt_good[i]  = (v[3] & v[2]) ^ ~(v[1] | v[0]);
      tt_fault[i] = ~(v[3] & v[2]);
    end
  endtask

  task automatic model(output logic [15:0] m, output logic [4:0] c,
                       output logic [3:0] f, output logic fv);
    m  = tt_good ^ tt_fault;
    c  = 5'($countones(m));
    fv = (m != 0);
    f  = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) f = 4'(i);
  endtask

  task automatic launch(input int d, output int lat, output int ndone,
                        output logic busy_e0, output logic [3:0] vec_e0,
                        output logic busy_dn, output logic [4:0] c,
                        output logic [15:0] m, output logic [3:0] f,
                        output logic fv);
    logic dn;
    @(negedge clk);
    if (d == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk);
    #1;
    if (d == 1) e0_1 = tick; else e0_3 = tick;
    busy_e0 = (d == 1) ? busy1 : busy3;
    vec_e0  = (d == 1) ? vec1 : vec3;
    lat = -1; ndone = 0; busy_dn = 1'b1; c = 'x; m = 'x; f = 'x; fv = 1'bx;
    for (int cy = 0; cy < 400; cy++) begin
      @(negedge clk);
      if (cy == 0) begin start1 = 1'b0; start3 = 1'b0; end
      dn = (d == 1) ? done1 : done3;
      if (dn) begin
        ndone++;
        if (lat < 0) begin
          lat     = cy;
          busy_dn = (d == 1) ? busy1 : busy3;
          c  = (d == 1) ? cnt1 : cnt3;
          m  = (d == 1) ? map1 : map3;
          f  = (d == 1) ? fv1  : fv3;
          fv = (d == 1) ? fval1 : fval3;
        end
      end
      if (lat >= 0 && cy >= lat + 4) break;
    end
  endtask

  task automatic test_reset();
    checks++; if ({vec1, busy1, done1, cnt1, map1, fv1, fval1} !== '0) begin
      errors++; $display("FAIL reset_dut1 got %h exp 0", {vec1, busy1, done1, cnt1, map1, fv1, fval1}); end
    checks++; if ({vec3, busy3, done3, cnt3, map3, fv3, fval3} !== '0) begin
      errors++; $display("FAIL reset_dut3 got %h exp 0", {vec3, busy3, done3, cnt3, map3, fv3, fval3}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b done=%b exp 0 0", busy1, done1); end
  endtask

  task automatic test_run(input string nm, input int d, input logic [15:0] g,
                          input logic [15:0] flt, input bit gl);
    int lat, nd, exp_lat;
    logic be, bd, fv, efv;
    logic [3:0] ve, f, ef;
    logic [4:0] c, ec;
    logic [15:0] m, em;
    tt_good = g; tt_fault = flt; glitch = gl;
    model(em, ec, ef, efv);
    exp_lat = 16 * (d == 1 ? 2 : 4);
    launch(d, lat, nd, be, ve, bd, c, m, f, fv);
    glitch = 1'b0;
    checks++; if (be !== 1'b1 || ve !== 4'd0) begin
      errors++; $display("FAIL %s_e0 busy=%b vec=%h exp 1 0", nm, be, ve); end
    checks++; if (lat !== exp_lat) begin
      errors++; $display("FAIL %s_latency got %0d exp %0d", nm, lat, exp_lat); end
    checks++; if (nd !== 1) begin
      errors++; $display("FAIL %s_done_pulses got %0d exp 1", nm, nd); end
    checks++; if (bd !== 1'b0) begin
      errors++; $display("FAIL %s_busy_at_done got %b exp 0", nm, bd); end
    checks++; if (c !== ec) begin
      errors++; $display("FAIL %s_cnt got %0d exp %0d", nm, c, ec); end
    checks++; if (m !== em) begin
      errors++; $display("FAIL %s_map got %h exp %h", nm, m, em); end
    checks++; if (fv !== efv) begin
      errors++; $display("FAIL %s_first_valid got %b exp %b", nm, fv, efv); end
    if (efv) begin
      checks++; if (f !== ef) begin
        errors++; $display("FAIL %s_first_vec got %h exp %h", nm, f, ef); end
    end
    c = (d == 1) ? cnt1 : cnt3;
    m = (d == 1) ? map1 : map3;
    checks++; if (c !== ec || m !== em) begin
      errors++; $display("FAIL %s_hold cnt=%0d map=%h exp %0d %h", nm, c, m, ec, em); end
  endtask

  task automatic test_spec_cases();
    logic [15:0] g, f;
    set_sa0(); g = tt_good; f = tt_fault;
    checks++; if ((g ^ f) !== 16'hEEEE) begin
      errors++; $display("FAIL cut_table got %h exp eeee", g ^ f); end
    test_run("exhaustive", 1, g, f, 1'b0);
    test_run("fault_free", 1, g, g, 1'b0);
    test_run("inverted", 1, g, ~g, 1'b0);
    test_run("settle3", 3, g, f, 1'b1);
    test_run("settle1_glitch", 1, g, f, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0, bad = 1'b0;
    set_sa0();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (vec1 == 4'd7) seen = 1'b1; else @(negedge clk);
    end
    checks++; if (!seen) begin
      errors++; $display("FAIL rstmid_reach_vec7 got %h exp 7", vec1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({vec1, busy1, done1, cnt1, map1, fv1, fval1} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %h exp 0", {vec1, busy1, done1, cnt1, map1, fv1, fval1}); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin
      errors++; $display("FAIL rstmid_no_done saw done/busy after abort exp none"); end
    test_run("after_reset", 1, tt_good, tt_fault, 1'b0);
  endtask

  task automatic test_start_repulse();
    int nd = 0, lat = -1;
    bit late_busy = 1'b0;
    set_sa0();
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    for (int cy = 0; cy < 80; cy++) begin
      @(negedge clk);
      if (cy <= 31) start1 = 1'($urandom_range(0, 1));
      else if (cy == 32) start1 = 1'b1;
      else start1 = 1'b0;
      if (done1) begin nd++; if (lat < 0) lat = cy; end
      if (cy >= 34 && busy1) late_busy = 1'b1;
    end
    checks++; if (nd !== 1 || lat !== 32) begin
      errors++; $display("FAIL repulse_done got %0d pulses at %0d exp 1 at 32", nd, lat); end
    checks++; if (late_busy) begin
      errors++; $display("FAIL repulse_start_in_done busy=1 exp 0"); end
    checks++; if (cnt1 !== 5'd12 || map1 !== 16'hEEEE) begin
      errors++; $display("FAIL repulse_result cnt=%0d map=%h exp 12 eeee", cnt1, map1); end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    bit ok_idle = 1'b1, ok_res = 1'b1, fin = 1'b0;
    set_sa0();
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    for (int cy = 0; cy < 106; cy++) begin
      @(negedge clk);
      if (done1) begin
        dq.push_back(cy);
        if (cnt1 !== 5'd12 || map1 !== 16'hEEEE || fv1 !== 4'd1) ok_res = 1'b0;
      end
      if (cy == 33 && (busy1 !== 1'b0 || done1 !== 1'b0)) ok_idle = 1'b0;
      if (cy == 34 && (busy1 !== 1'b1 || vec1 !== 4'd0)) ok_idle = 1'b0;
    end
    start1 = 1'b0;
    checks++; if (dq.size() != 3 || dq[0] != 32 || dq[1] != 66 || dq[2] != 100) begin
      errors++; $display("FAIL b2b_done_times got %p exp '{32,66,100}", dq); end
    checks++; if (!ok_idle) begin
      errors++; $display("FAIL b2b_idle_gap idle cycle not exactly one exp busy 0 then 1"); end
    checks++; if (!ok_res) begin
      errors++; $display("FAIL b2b_results wrong at a done exp 12 eeee 1"); end
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (done1) fin = 1'b1;
    end
    checks++; if (!fin) begin
      errors++; $display("FAIL b2b_final_done got none exp 1"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] g, f;
    for (int it = 0; it < 6; it++) begin
      g = 16'($urandom);
      case (it % 3)
        0: f = 16'($urandom);
        1: f = g ^ (16'h1 << $urandom_range(0, 15));
        default: f = g ^ 16'h8000;
      endcase
      test_run($sformatf("rand%0d", it), (it % 2 == 0) ? 1 : 3, g, f, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_spec_cases();
    test_reset_mid_run();
    test_start_repulse();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
